// File: rtl/toast_alu_arbiter.sv
// toast_alu_arbiter
// Shares one combinational toast_alu between two requesters (req0 = execute
// stage, req1 = auxiliary unit). One operation is in flight at a time:
// IDLE accepts a request, EXEC lets the ALU evaluate the registered operands,
// RESP holds the captured result until the consumer takes it.
//
// Build option:
//   TOAST_ALU_ARB_RR_EN  defined   -> round-robin between the two requesters
//                        undefined -> fixed priority, req0 always wins
//
// ID_W must stay 1: the response ID names one of exactly two requesters.

module toast_alu_arbiter #(
    parameter int ID_W = 1
) (
    input  logic            clk_i,
    input  logic            resetn_i,

    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [3:0]      req0_ctrl_i,
    input  logic [31:0]     req0_op1_i,
    input  logic [31:0]     req0_op2_i,

    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [3:0]      req1_ctrl_i,
    input  logic [31:0]     req1_op1_i,
    input  logic [31:0]     req1_op2_i,

    output logic [3:0]      alu_ctrl_o,
    output logic [31:0]     alu_op1_o,
    output logic [31:0]     alu_op2_o,
    input  logic [31:0]     alu_result_i,
    input  logic            alu_test_i,

    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [ID_W-1:0] rsp_id_o,
    output logic [31:0]     rsp_result_o,
    output logic            rsp_test_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;

    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic [31:0]     alu_op1_q, alu_op1_d;
    logic [31:0]     alu_op2_q, alu_op2_d;
    logic [ID_W-1:0] id_q, id_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic            rsp_test_q, rsp_test_d;

`ifdef TOAST_ALU_ARB_RR_EN
    logic            last_grant_q, last_grant_d;
`endif

    logic            grant_valid;
    logic            grant_id;
    logic            handshake;

    // Pick a winner among the valid requesters (only meaningful in IDLE)
    always_comb begin
        grant_valid = req0_valid_i | req1_valid_i;
`ifdef TOAST_ALU_ARB_RR_EN
        // On contention hand the slot to whoever did not win last time
        if (req0_valid_i && req1_valid_i) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = ~req0_valid_i;
        end
`else
        // Fixed priority: req0 wins whenever it is valid
        grant_id = ~req0_valid_i;
`endif
    end

    // Next-state logic: one operation walks IDLE -> EXEC -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: only the granted requester sees ready, and only in IDLE
    always_comb begin
        req0_ready_o = (state_q == ST_IDLE) && grant_valid && !grant_id;
        req1_ready_o = (state_q == ST_IDLE) && grant_valid &&  grant_id;
        handshake    = req0_ready_o | req1_ready_o;
    end

    // Datapath: latch the winning payload, capture the ALU, retire the response
    always_comb begin
        alu_ctrl_d   = alu_ctrl_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_test_d   = rsp_test_q;
`ifdef TOAST_ALU_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        if (handshake) begin
            alu_ctrl_d = grant_id ? req1_ctrl_i : req0_ctrl_i;
            alu_op1_d  = grant_id ? req1_op1_i  : req0_op1_i;
            alu_op2_d  = grant_id ? req1_op2_i  : req0_op2_i;
            id_d       = ID_W'(grant_id);
`ifdef TOAST_ALU_ARB_RR_EN
            last_grant_d = grant_id;
`endif
        end

        if (state_q == ST_EXEC) begin
            rsp_result_d = alu_result_i;
            rsp_test_d   = alu_test_i;
            rsp_id_d     = id_q;
            rsp_valid_d  = 1'b1;
        end

        if ((state_q == ST_RESP) && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset drops any in-flight work silently
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q      <= ST_IDLE;
            alu_ctrl_q   <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_test_q   <= 1'b0;
`ifdef TOAST_ALU_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_test_q   <= rsp_test_d;
`ifdef TOAST_ALU_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign alu_ctrl_o   = alu_ctrl_q;
    assign alu_op1_o    = alu_op1_q;
    assign alu_op2_o    = alu_op2_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_test_o   = rsp_test_q;

endmodule

// File: tb/tb_toast_alu_arbiter.sv
// Testbench for toast_alu_arbiter.
// A behavioural toast_alu stand-in drives alu_result_i/alu_test_i. The bench
// predicts the winner of each round from the arbitration rule, the result from
// the ALU function, and the response timing from the fixed three-phase protocol.

module tb_toast_alu_arbiter;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        req0_valid_i, req0_ready_o;
    logic [3:0]  req0_ctrl_i;
    logic [31:0] req0_op1_i, req0_op2_i;
    logic        req1_valid_i, req1_ready_o;
    logic [3:0]  req1_ctrl_i;
    logic [31:0] req1_op1_i, req1_op2_i;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_op1_o, alu_op2_o;
    logic [31:0] alu_result_i;
    logic        alu_test_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [0:0]  rsp_id_o;
    logic [31:0] rsp_result_o;
    logic        rsp_test_o;

    int compared   = 0;
    int mismatched = 0;

    // Bench-side requester state and arbitration memory
    logic        v0, v1;
    logic [3:0]  c0, c1;
    logic [31:0] a0, b0, a1, b1;
    logic        exp_last;

    always #5 clk_i = ~clk_i;

    toast_alu_arbiter #(.ID_W(1)) dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_ctrl_i  (req0_ctrl_i),
        .req0_op1_i   (req0_op1_i),
        .req0_op2_i   (req0_op2_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_ctrl_i  (req1_ctrl_i),
        .req1_op1_i   (req1_op1_i),
        .req1_op2_i   (req1_op2_i),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_op1_o    (alu_op1_o),
        .alu_op2_o    (alu_op2_o),
        .alu_result_i (alu_result_i),
        .alu_test_i   (alu_test_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_test_o   (rsp_test_o)
    );

    // Behavioural ALU: {test, result}; unknown codes give 0/0
    function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        t;
        r = 32'd0;
        t = 1'b0;
        case (c)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  begin t = ($signed(a) < $signed(b)); r = {31'd0, t}; end
            ALU_SLTU: begin t = (a < b); r = {31'd0, t}; end
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_BEQ:  t = (a == b);
            default:  ;
        endcase
        return {t, r};
    endfunction

    assign {alu_test_i, alu_result_i} = alu_ref(alu_ctrl_o, alu_op1_o, alu_op2_o);

    // Arbitration rule applied to the bench's own view of who is requesting
    function automatic logic pickWinner();
        if (v0 && v1) begin
`ifdef TOAST_ALU_ARB_RR_EN
            return ~exp_last;
`else
            return 1'b0;
`endif
        end
        return v0 ? 1'b0 : 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        req0_valid_i = v0;
        req0_ctrl_i  = c0;
        req0_op1_i   = a0;
        req0_op2_i   = b0;
        req1_valid_i = v1;
        req1_ctrl_i  = c1;
        req1_op1_i   = a1;
        req1_op2_i   = b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req0_ready"}, 32'(req0_ready_o), 32'd0);
        checkOutput({tag, "_req1_ready"}, 32'(req1_ready_o), 32'd0);
        checkOutput({tag, "_alu_ctrl"},   32'(alu_ctrl_o),   32'd0);
        checkOutput({tag, "_alu_op1"},    alu_op1_o,         32'd0);
        checkOutput({tag, "_alu_op2"},    alu_op2_o,         32'd0);
        checkOutput({tag, "_rsp_valid"},  32'(rsp_valid_o),  32'd0);
        checkOutput({tag, "_rsp_id"},     32'(rsp_id_o),     32'd0);
        checkOutput({tag, "_rsp_result"}, rsp_result_o,      32'd0);
        checkOutput({tag, "_rsp_test"},   32'(rsp_test_o),   32'd0);
    endtask

    // One full transaction starting just after an edge with the DUT idle:
    // grant, execute, respond, hold for bp stalled cycles, then retire.
    task automatic runOp(input int bp);
        logic        win;
        logic [32:0] exp;
        logic [3:0]  wc;
        logic [31:0] wa, wb;
        applyStimulus();
        rsp_ready_i = 1'b0;
        win = pickWinner();
        wc  = win ? c1 : c0;
        wa  = win ? a1 : a0;
        wb  = win ? b1 : b0;
        exp = alu_ref(wc, wa, wb);
        #1;
        checkOutput("idle_req0_ready", 32'(req0_ready_o), 32'(!win));
        checkOutput("idle_req1_ready", 32'(req1_ready_o), 32'(win));

        @(posedge clk_i); #1;
        exp_last = win;
        if (win) v1 = 1'b0; else v0 = 1'b0;
        applyStimulus();
        checkOutput("exec_alu_ctrl",   32'(alu_ctrl_o), 32'(wc));
        checkOutput("exec_alu_op1",    alu_op1_o, wa);
        checkOutput("exec_alu_op2",    alu_op2_o, wb);
        checkOutput("exec_rsp_valid",  32'(rsp_valid_o), 32'd0);
        checkOutput("exec_req0_ready", 32'(req0_ready_o), 32'd0);
        checkOutput("exec_req1_ready", 32'(req1_ready_o), 32'd0);

        for (int k = 0; k <= bp; k++) begin
            @(posedge clk_i); #1;
            checkOutput("resp_valid",      32'(rsp_valid_o), 32'd1);
            checkOutput("resp_id",         32'(rsp_id_o), 32'(win));
            checkOutput("resp_result",     rsp_result_o, exp[31:0]);
            checkOutput("resp_test",       32'(rsp_test_o), 32'(exp[32]));
            checkOutput("resp_req0_ready", 32'(req0_ready_o), 32'd0);
            checkOutput("resp_req1_ready", 32'(req1_ready_o), 32'd0);
        end

        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        checkOutput("retire_valid", 32'(rsp_valid_o), 32'd0);
    endtask

    // Reset asserted while an operation sits in EXEC (phase 0) or RESP (phase 1)
    task automatic resetMid(input int phase);
        v0 = 1'b1; c0 = ALU_ADD; a0 = 32'd100; b0 = 32'd23;
        v1 = 1'b0;
        applyStimulus();
        rsp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        v0 = 1'b0;
        applyStimulus();
        if (phase == 1) begin
            @(posedge clk_i); #1;
        end
        resetn_i = 1'b0;
        @(posedge clk_i); #1;
        resetn_i = 1'b1;
        exp_last = 1'b1;
        checkAllZero(phase == 1 ? "rst_resp" : "rst_exec");
        @(posedge clk_i); #1;
        checkOutput("rst_no_rsp", 32'(rsp_valid_o), 32'd0);
        v0 = 1'b1; c0 = ALU_OR;  a0 = 32'hF0F0_0000; b0 = 32'h0000_0F0F;
        v1 = 1'b1; c1 = ALU_AND; a1 = 32'hFFFF_0000; b1 = 32'h0FF0_FFFF;
        runOp(0);
        v1 = 1'b0;
        applyStimulus();
    endtask

    task automatic newOp(input int n);
        logic [3:0]  c;
        logic [31:0] a, b;
        c = 4'($urandom_range(0, 15));
        a = $urandom;
        b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 31));
        if (n == 0) begin v0 = 1'b1; c0 = c; a0 = a; b0 = b; end
        else        begin v1 = 1'b1; c1 = c; a1 = a; b1 = b; end
    endtask

    initial begin
        resetn_i    = 1'b0;
        rsp_ready_i = 1'b0;
        v0 = 1'b0; c0 = 4'd0; a0 = 32'd0; b0 = 32'd0;
        v1 = 1'b0; c1 = 4'd0; a1 = 32'd0; b1 = 32'd0;
        exp_last = 1'b1;
        applyStimulus();
        repeat (2) @(posedge clk_i);
        #1;
        checkAllZero("reset");
        resetn_i = 1'b1;
        $display("[TB] reset checked, starting directed steps");

        // Single ADD from req0
        v0 = 1'b1; c0 = ALU_ADD; a0 = 32'd5; b0 = 32'd7;
        runOp(0);

        // Test-result ops from req1
        v1 = 1'b1; c1 = ALU_SLT;  a1 = 32'hFFFF_FFFF; b1 = 32'd1;
        runOp(0);
        v1 = 1'b1; c1 = ALU_SLTU; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
        runOp(0);

        // Contention with both requesters continuously valid
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; c0 = ALU_SUB; a0 = 32'd10;          b0 = 32'd3;
            v1 = 1'b1; c1 = ALU_SRA; a1 = 32'h8000_0000;   b1 = 32'd4;
            runOp(0);
        end
        v0 = 1'b0; v1 = 1'b0;
        applyStimulus();

        // Backpressure: consumer stalls five cycles
        v0 = 1'b1; c0 = ALU_XOR; a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678;
        runOp(5);

        // Unknown opcode passes through and yields 0/0
        v1 = 1'b1; c1 = 4'd15; a1 = 32'hAAAA_5555; b1 = 32'h5555_AAAA;
        runOp(1);

        // Reset during EXEC and during RESP
        resetMid(0);
        resetMid(1);

        $display("[TB] starting randomized rounds");
        for (int r = 0; r < 60; r++) begin
            if (!v0 && ($urandom_range(0, 1) == 1)) newOp(0);
            if (!v1 && ($urandom_range(0, 1) == 1)) newOp(1);
            if (!v0 && !v1) newOp(int'($urandom_range(0, 1)));
            runOp(int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
